// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared definitions for the UART transmitter: frame width, FSM states and
// the mapping from FSM state to serial line level.
package mfp_uart_transmitter_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Line level for a given state; data_bit is the shifter LSB.
  function automatic logic line_level(input tx_state_e st, input logic data_bit);
    logic lvl;
    case (st)
      ST_START: lvl = 1'b0;
      ST_DATA:  lvl = data_bit;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. A full FIFO refuses pushes even when a
// pop happens on the same edge. A freshly pushed byte becomes visible to the
// reader one edge after the push (no bypass path).
module mfp_uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  avail_q;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CNT_FULL);
  // avail_q lags the count by one edge, which delays visibility of new data.
  assign empty   = !avail_q || (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  // Read is combinational so the FSM can load the shifter on the pop edge.
  assign rd_data = mem_q[rd_ptr_q];

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, count and the delayed visibility flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      avail_q <= (count_q != '0);
    end
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop shifter paced by
// an integer baud divider. Back-to-back frames have no idle gap.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  input  logic [FRAME_BITS-1:0]    wr_data,
  output logic                     wr_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("mfp_uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
  endgenerate

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [FRAME_BITS-1:0] fifo_rd_data;

  mfp_uart_tx_fifo #(
    .WIDTH      (FRAME_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (wr_valid),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

  // Next-state logic: baud pacing, bit sequencing, FIFO pops and line level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CNT_ONE;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_d = line_level(state_d, shift_d[0]);
  end

  // State, counters, shifter and the glitch-free line register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Self-checking bench for mfp_uart_transmitter at DIV=16: hand-written frame
// tables for cycle-exact line checks plus a serial decoder scoreboard.
module tb_mfp_uart_transmitter;

  localparam int DIV = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx, busy;
  logic [3:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  bit         mon_en = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i is the i-th bit on the wire (start first)
  } vec_t;
  vec_t vecs[4];

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY (16),
    .BAUD_RATE       (1),
    .FIFO_DEPTH_LOG2 (3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    logic acc;
    @(negedge clock);
    wr_valid = 1'b1;
    wr_data  = d;
    acc      = wr_ready;
    @(posedge clock);
    #1 wr_valid = 1'b0;
    if (acc && mon_en) sb_q.push_back(d);
    $display("write %02h accepted=%0d", d, acc);
  endtask

  // Checks tx on every cycle of nbits bit periods, starting at the next negedge.
  task automatic expect_line(input logic [19:0] bits, input int nbits, input string name);
    int bad;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clock);
        if (tx !== bits[b]) bad++;
      end
      check($sformatf("%s bit%0d wrong-cycles", name, b), bad, 0);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clock);
    while (busy === 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic quiet_window(input int ncyc, input string name);
    int lows = 0;
    int busys = 0;
    repeat (ncyc) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check({name, " tx-low cycles"}, lows, 0);
    check({name, " busy cycles"}, busys, 0);
  endtask

  // Scoreboard: decode frames from the line mid-bit and compare to writes.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    logic       start_lvl, stop_lvl;
    forever begin
      @(negedge clock);
      if (mon_en && reset_n && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clock);
        start_lvl = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clock);
          got[i] = tx;
        end
        repeat (DIV) @(negedge clock);
        stop_lvl = tx;
        check("mid start bit", start_lvl, 1'b0);
        check("mid stop bit", stop_lvl, 1'b1);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected frame: got %02h, expected no frame", got);
        end else begin
          exp = sb_q.pop_front();
          check("frame data", got, exp);
        end
        $display("frame %02h", got);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    vecs[0] = '{data: 8'h55, line: 10'h2AA};
    vecs[1] = '{data: 8'h00, line: 10'h200};
    vecs[2] = '{data: 8'hFF, line: 10'h3FE};
    vecs[3] = '{data: 8'h81, line: 10'h302};

    // Reset state and writes ignored while in reset.
    repeat (3) @(negedge clock);
    check("reset tx", tx, 1'b1);
    check("reset wr_ready", wr_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset fifo_count", fifo_count, 0);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    repeat (2) @(negedge clock);
    wr_valid = 1'b0;
    check("fifo_count after write in reset", fifo_count, 0);
    reset_n = 1'b1;
    quiet_window(200, "after reset release");

    // Single-frame table: cycle-exact line shape and busy fall.
    foreach (vecs[i]) begin
      write_byte(vecs[i].data);
      @(negedge clock);
      check("tx before start (k)", tx, 1'b1);
      @(negedge clock);
      check("tx before start (k+1)", tx, 1'b1);
      check("busy while queued", busy, 1'b1);
      expect_line({10'h000, vecs[i].line}, 10, $sformatf("single %02h", vecs[i].data));
      @(negedge clock);
      check("busy after frame", busy, 1'b0);
      check("tx idle after frame", tx, 1'b1);
    end

    // Back-to-back frames with no gap.
    write_byte(8'hA5);
    write_byte(8'h3C);
    @(negedge clock);
    check("b2b tx before start", tx, 1'b1);
    expect_line({10'h278, 10'h34A}, 20, "b2b");
    @(negedge clock);
    check("b2b busy after 320", busy, 1'b0);

    // FIFO fill: ten offers, the tenth refused.
    for (int i = 0; i < 10; i++) begin
      logic acc;
      @(negedge clock);
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      acc      = wr_ready;
      check($sformatf("fill wr_ready cycle %0d", i), acc, (i < 9) ? 1'b1 : 1'b0);
      @(posedge clock);
      if (acc) sb_q.push_back(8'(i));
      $display("write %02h accepted=%0d", 8'(i), acc);
    end
    #1 wr_valid = 1'b0;
    @(negedge clock);
    check("fill fifo_count", fifo_count, 8);
    check("fill wr_ready low", wr_ready, 1'b0);
    wait_idle(9 * 10 * DIV + 50, "fill drained");
    check("fill scoreboard empty", sb_q.size(), 0);

    // Push on the same edge as the stop-bit-end pop.
    write_byte(8'hC3);
    write_byte(8'h5A);
    repeat (10 * DIV) @(posedge clock);
    @(negedge clock);
    check("collision pre count", fifo_count, 1);
    check("collision pre tx stop", tx, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 8'hE7;
    if (wr_ready) sb_q.push_back(8'hE7);
    @(posedge clock);
    #1 wr_valid = 1'b0;
    $display("write e7 on stop-bit end");
    @(negedge clock);
    check("collision count unchanged", fifo_count, 1);
    check("collision next start", tx, 1'b0);
    wait_idle(3 * 10 * DIV, "collision drained");
    check("collision scoreboard empty", sb_q.size(), 0);

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    mon_en = 1'b0;
    write_byte(8'hF0);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (70) @(posedge clock);
    #2;
    check("midframe tx data bit3", tx, 1'b0);
    check("midframe fifo_count", fifo_count, 2);
    reset_n = 1'b0;
    #1;
    check("async reset tx", tx, 1'b1);
    check("async reset fifo_count", fifo_count, 0);
    check("async reset busy", busy, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    quiet_window(200, "after midframe reset");
    mon_en = 1'b1;

    check("final scoreboard empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
